// File: rtl/ball_engine.sv
// Pong ball engine: serve / play / point / game-over sequencing with wall and left-paddle collisions.
// Optional BALL_SPEEDUP_EN: horizontal step grows by one pixel per four returns, capped at STEP+2.
module ball_engine #(
  parameter int unsigned STEP        = 2,
  parameter int unsigned SERVE_DELAY = 60,
  parameter int unsigned WIN_SCORE   = 9
) (
  input  logic       slowclock,
  input  logic       reset,
  input  logic [9:0] paddle_y,
  output logic [9:0] ballx,
  output logic [9:0] bally,
  output logic [3:0] Score1,
  output logic [3:0] Score2,
  output logic       game_over
);

  localparam int unsigned XW = 10;
  localparam int unsigned EW = 11;
  localparam int unsigned CW = 7;
  localparam int unsigned SW = 4;

  localparam logic [XW-1:0] CENTRE_X   = XW'(310);
  localparam logic [XW-1:0] CENTRE_Y   = XW'(230);
  localparam logic [EW-1:0] X_RIGHT    = EW'(590);
  localparam logic [EW-1:0] Y_BOTTOM   = EW'(460);
  localparam logic [EW-1:0] PAD_LEFT   = EW'(60);
  localparam logic [EW-1:0] PAD_FACE   = EW'(90);
  localparam logic [EW-1:0] PAD_H      = EW'(120);
  localparam logic [EW-1:0] BALL_SZ    = EW'(20);
  localparam logic [EW-1:0] Y_STEP     = EW'(STEP);
  localparam logic [CW-1:0] DELAY_LAST = CW'(SERVE_DELAY - 1);
  localparam logic [SW-1:0] WIN        = SW'(WIN_SCORE);

  typedef enum logic [1:0] {SERVE, PLAY, POINT, OVER} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          vx_right, vx_right_nxt;
  logic          vy_up, vy_up_nxt;
  logic          serve_bit, serve_bit_nxt;
  logic [XW-1:0] ballx_nxt, bally_nxt;
  logic [SW-1:0] score1_nxt, score2_nxt, score1_inc;
  logic          game_over_nxt;

  logic [EW-1:0] bx, by, py, x_step;
  logic          hit, miss, win_hit, serve_done;

  // Horizontal step, optionally sped up by return count
`ifdef BALL_SPEEDUP_EN
  logic [1:0] bonus;
  always_comb begin
    bonus  = (Score1[3:2] == 2'd3) ? 2'd2 : Score1[3:2];
    x_step = EW'(STEP) + EW'(bonus);
  end
`else
  always_comb x_step = EW'(STEP);
`endif

  // Collision predicates on zero-extended operands; subtraction is moved across to avoid wrap
  always_comb begin
    bx         = {1'b0, ballx};
    by         = {1'b0, bally};
    py         = {1'b0, paddle_y};
    hit        = !vx_right && (bx >= PAD_LEFT) && (bx <= PAD_FACE + x_step) &&
                 (by + BALL_SZ > py) && (by < py + PAD_H);
    miss       = !vx_right && !hit && (bx < x_step);
    score1_inc = (Score1 < WIN) ? Score1 + SW'(1) : Score1;
    win_hit    = hit && (score1_inc == WIN);
    serve_done = (cnt == DELAY_LAST);
  end

  always_ff @(posedge slowclock or negedge reset) begin
    if (!reset) begin
      state     <= SERVE;
      cnt       <= '0;
      vx_right  <= 1'b0;
      vy_up     <= 1'b0;
      serve_bit <= 1'b0;
      ballx     <= CENTRE_X;
      bally     <= CENTRE_Y;
      Score1    <= '0;
      Score2    <= '0;
      game_over <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      vx_right  <= vx_right_nxt;
      vy_up     <= vy_up_nxt;
      serve_bit <= serve_bit_nxt;
      ballx     <= ballx_nxt;
      bally     <= bally_nxt;
      Score1    <= score1_nxt;
      Score2    <= score2_nxt;
      game_over <= game_over_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      SERVE: if (serve_done) state_nxt = PLAY;
      PLAY:  if (miss || win_hit) state_nxt = POINT;
      POINT: state_nxt = (Score1 == WIN || Score2 == WIN) ? OVER : SERVE;
      OVER:  state_nxt = OVER;
    endcase
  end

  always_comb begin
    cnt_nxt       = cnt;
    vx_right_nxt  = vx_right;
    vy_up_nxt     = vy_up;
    serve_bit_nxt = serve_bit;
    ballx_nxt     = ballx;
    bally_nxt     = bally;
    score1_nxt    = Score1;
    score2_nxt    = Score2;
    game_over_nxt = (state_nxt == OVER);
    unique case (state)
      SERVE: begin
        if (serve_done) begin
          cnt_nxt      = '0;
          vx_right_nxt = 1'b0;
          vy_up_nxt    = serve_bit;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      PLAY: begin
        if (!vx_right) begin
          if (hit) begin
            ballx_nxt    = XW'(PAD_FACE);
            vx_right_nxt = 1'b1;
            score1_nxt   = score1_inc;
          end else if (miss) begin
            ballx_nxt  = '0;
            score2_nxt = (Score2 < WIN) ? Score2 + SW'(1) : Score2;
          end else begin
            ballx_nxt = XW'(bx - x_step);
          end
        end else if (bx + x_step >= X_RIGHT) begin
          ballx_nxt    = XW'(X_RIGHT);
          vx_right_nxt = 1'b0;
        end else begin
          ballx_nxt = XW'(bx + x_step);
        end
        // Vertical motion is independent so corner hits apply both reflections
        if (vy_up) begin
          if (by < Y_STEP) begin
            bally_nxt = '0;
            vy_up_nxt = 1'b0;
          end else begin
            bally_nxt = XW'(by - Y_STEP);
          end
        end else if (by + Y_STEP > Y_BOTTOM) begin
          bally_nxt = XW'(Y_BOTTOM);
          vy_up_nxt = 1'b1;
        end else begin
          bally_nxt = XW'(by + Y_STEP);
        end
      end
      POINT: begin
        ballx_nxt = CENTRE_X;
        bally_nxt = CENTRE_Y;
        cnt_nxt   = '0;
        if (state_nxt == SERVE) begin
          serve_bit_nxt = ~serve_bit;
          vy_up_nxt     = ~serve_bit;
          vx_right_nxt  = 1'b0;
        end
      end
      OVER: begin
      end
    endcase
  end

endmodule
